// File: rtl/ram_req_master.sv
// ram_req_master: command FIFO in front of a single-port RAM request port.
// Commands are issued one at a time. Each one returns exactly one response
// carrying read data and a completion status. A watchdog bounds the wait for
// ram_ready.
module ram_req_master #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_wr_rd,
    input  logic [ADDR_WIDTH-1:0]         cmd_addr,
    input  logic [DATA_WIDTH-1:0]         cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_wr_rd,
    output logic [ADDR_WIDTH-1:0]         rsp_addr,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_status,
    output logic                          ram_en,
    output logic                          ram_wr_rd,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    output logic                          ram_valid,
    input  logic [DATA_WIDTH-1:0]         ram_dout,
    input  logic                          ram_ready,
    input  logic                          ram_error,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT) + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_RAM_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic                  fifo_wr_rd [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;

    logic push_c;
    logic pop_c;

    logic                  head_wr_rd;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    state_t state;
    state_t state_nxt;

    assign push_c = cmd_valid && cmd_ready;
    assign pop_c  = (state == IDLE) && (fifo_count != '0);

    assign head_wr_rd = fifo_wr_rd[rd_ptr];
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt = fifo_count;
        case ({push_c, pop_c})
            2'b10:   count_nxt = fifo_count + CNT_W'(1);
            2'b01:   count_nxt = fifo_count - CNT_W'(1);
            default: count_nxt = fifo_count;
        endcase
    end

    // FIFO pointers and occupancy. cmd_ready follows the registered count,
    // so a pop cannot open a slot to a push in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            cmd_ready  <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= count_nxt;
            cmd_ready  <= (count_nxt != FULL_CNT);
        end
    end

    // FIFO storage. It needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_wr_rd[wr_ptr] <= cmd_wr_rd;
            fifo_addr[wr_ptr]  <= cmd_addr;
            fifo_data[wr_ptr]  <= cmd_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM with registered RAM and response outputs
    // ------------------------------------------------------------------
    logic [WD_W-1:0]       wd;
    logic [WD_W-1:0]       wd_nxt;
    logic                  work_wr_rd;
    logic                  work_wr_rd_nxt;
    logic [ADDR_WIDTH-1:0] work_addr;
    logic [ADDR_WIDTH-1:0] work_addr_nxt;

    logic                  ram_en_nxt;
    logic                  ram_valid_nxt;
    logic                  ram_wr_rd_nxt;
    logic [ADDR_WIDTH-1:0] ram_addr_nxt;
    logic [DATA_WIDTH-1:0] ram_din_nxt;

    logic                  rsp_valid_nxt;
    logic                  rsp_wr_rd_nxt;
    logic [ADDR_WIDTH-1:0] rsp_addr_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
    logic [1:0]            rsp_status_nxt;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wd         <= '0;
            work_wr_rd <= 1'b0;
            work_addr  <= '0;
            ram_en     <= 1'b0;
            ram_valid  <= 1'b0;
            ram_wr_rd  <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            rsp_valid  <= 1'b0;
            rsp_wr_rd  <= 1'b0;
            rsp_addr   <= '0;
            rsp_rdata  <= '0;
            rsp_status <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            wd         <= wd_nxt;
            work_wr_rd <= work_wr_rd_nxt;
            work_addr  <= work_addr_nxt;
            ram_en     <= ram_en_nxt;
            ram_valid  <= ram_valid_nxt;
            ram_wr_rd  <= ram_wr_rd_nxt;
            ram_addr   <= ram_addr_nxt;
            ram_din    <= ram_din_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_wr_rd  <= rsp_wr_rd_nxt;
            rsp_addr   <= rsp_addr_nxt;
            rsp_rdata  <= rsp_rdata_nxt;
            rsp_status <= rsp_status_nxt;
            busy       <= (state_nxt != IDLE) || (count_nxt != '0);
        end
    end

    // Next state and next output values; everything holds unless changed.
    always_comb begin
        state_nxt      = state;
        wd_nxt         = wd;
        work_wr_rd_nxt = work_wr_rd;
        work_addr_nxt  = work_addr;
        ram_en_nxt     = ram_en;
        ram_valid_nxt  = ram_valid;
        ram_wr_rd_nxt  = ram_wr_rd;
        ram_addr_nxt   = ram_addr;
        ram_din_nxt    = ram_din;
        rsp_valid_nxt  = rsp_valid;
        rsp_wr_rd_nxt  = rsp_wr_rd;
        rsp_addr_nxt   = rsp_addr;
        rsp_rdata_nxt  = rsp_rdata;
        rsp_status_nxt = rsp_status;

        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    state_nxt      = ISSUE;
                    wd_nxt         = '0;
                    work_wr_rd_nxt = head_wr_rd;
                    work_addr_nxt  = head_addr;
                    ram_en_nxt     = 1'b1;
                    ram_valid_nxt  = 1'b1;
                    ram_wr_rd_nxt  = head_wr_rd;
                    ram_addr_nxt   = head_addr;
                    ram_din_nxt    = head_data;
                end
            end

            ISSUE: begin
                if (ram_ready) begin
                    // Completion takes priority over a watchdog expiry in the same cycle.
                    state_nxt      = RESP;
                    rsp_valid_nxt  = 1'b1;
                    rsp_wr_rd_nxt  = work_wr_rd;
                    rsp_addr_nxt   = work_addr;
                    rsp_status_nxt = ram_error ? ST_RAM_ERR : ST_OK;
                    rsp_rdata_nxt  = (!work_wr_rd && !ram_error) ? ram_dout : '0;
                    ram_en_nxt     = 1'b0;
                    ram_valid_nxt  = 1'b0;
                    ram_wr_rd_nxt  = 1'b0;
                    ram_addr_nxt   = '0;
                    ram_din_nxt    = '0;
                end else if (wd == WD_LAST) begin
                    state_nxt      = RESP;
                    rsp_valid_nxt  = 1'b1;
                    rsp_wr_rd_nxt  = work_wr_rd;
                    rsp_addr_nxt   = work_addr;
                    rsp_status_nxt = ST_TIMEOUT;
                    rsp_rdata_nxt  = '0;
                    ram_en_nxt     = 1'b0;
                    ram_valid_nxt  = 1'b0;
                    ram_wr_rd_nxt  = 1'b0;
                    ram_addr_nxt   = '0;
                    ram_din_nxt    = '0;
                end else begin
                    wd_nxt = wd + WD_W'(1);
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
